// File: rtl/zelda_pkg.sv
// Shared definitions for the zelda game datapath controllers.
// States, phase-strobe bit order and default pacing constants.
package zelda_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_GEN   = 3'd2,
    ST_APPLY = 3'd3,
    ST_REQ   = 3'd4,
    ST_DRAW  = 3'd5
  } state_t;

  // {init, idle, gen_move, apply_move, draw}
  localparam int STB_INIT  = 4;
  localparam int STB_IDLE  = 3;
  localparam int STB_GEN   = 2;
  localparam int STB_APPLY = 1;
  localparam int STB_DRAW  = 0;

  localparam int unsigned DEF_MOVE_DIV     = 4;
  localparam int unsigned DEF_INIT_CYCLES  = 2;
  localparam int unsigned DEF_DRAW_TIMEOUT = 4096;

  function automatic logic [4:0] phase_strobes(state_t s);
    logic [4:0] v;
    v = '0;
    unique case (s)
      ST_INIT:  v[STB_INIT]  = 1'b1;
      ST_IDLE:  v[STB_IDLE]  = 1'b1;
      ST_GEN:   v[STB_GEN]   = 1'b1;
      ST_APPLY: v[STB_APPLY] = 1'b1;
      ST_REQ:   v = '0;
      ST_DRAW:  v[STB_DRAW]  = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/enemy_control_if.sv
// Enemy controller bus: game inputs, VGA arbiter handshake,
// phase strobes and status toward the enemy block.
interface enemy_control_if;
  logic       enable;
  logic       frame_tick;
  logic       draw_grant;
  logic       draw_done;
  logic       init;
  logic       idle;
  logic       gen_move;
  logic       apply_move;
  logic       draw;
  logic       draw_req;
  logic       frame_overrun;
  logic       draw_timeout;
  logic [7:0] move_phase;

  modport master (
    input  enable, frame_tick, draw_grant, draw_done,
    output init, idle, gen_move, apply_move, draw,
    output draw_req, frame_overrun, draw_timeout, move_phase
  );

  modport slave (
    output enable, frame_tick, draw_grant, draw_done,
    input  init, idle, gen_move, apply_move, draw,
    input  draw_req, frame_overrun, draw_timeout, move_phase
  );
endinterface

// File: rtl/enemy_control_divider.sv
// Modulo-DIV tick counter used to pace sprite movement.
// wrap flags the last count so the caller can act on it.
module move_rate_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic       wrap,
  output logic [7:0] count
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/enemy_control.sv
// Enemy sequencing controller: paces moves from the frame tick,
// arbitrates for the VGA port and supervises the draw phase.
module enemy_control
  import zelda_pkg::*;
#(
  parameter int unsigned MOVE_DIV     = DEF_MOVE_DIV,
  parameter int unsigned INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int unsigned DRAW_TIMEOUT = DEF_DRAW_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  enemy_control_if.master bus
);

  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(DRAW_TIMEOUT - 1);

  state_t      state;
  state_t      next;
  logic [3:0]  init_cnt;
  logic [15:0] tmo_cnt;
  logic        advance;
  logic        wrap;
  logic        tmo_hit;
  logic        overrun_q;
  logic        timeout_q;
  logic [4:0]  stb;
  logic [7:0]  phase;

  move_rate_divider #(
    .DIV(MOVE_DIV)
  ) u_div (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
    .wrap    (wrap),
    .count   (phase)
  );

  always_comb begin
    next    = state;
    advance = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) next = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.frame_tick && bus.enable) begin
          advance = 1'b1;
          next    = wrap ? ST_GEN : ST_REQ;
        end
      end
      ST_GEN:   next = ST_APPLY;
      ST_APPLY: next = ST_REQ;
      ST_REQ: begin
        if (bus.draw_grant) next = ST_DRAW;
      end
      ST_DRAW: begin
        if (bus.draw_done) begin
          next = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          next    = ST_IDLE;
          tmo_hit = 1'b1;
        end
      end
      default: next = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      tmo_cnt   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= next;
      if (state == ST_INIT && init_cnt != INIT_LAST) begin
        init_cnt <= init_cnt + 4'd1;
      end
      // cleared outside DRAW so every entry starts from zero
      if (state == ST_DRAW) begin
        if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (bus.frame_tick && state != ST_IDLE) overrun_q <= 1'b1;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign stb = phase_strobes(state);

  assign bus.init          = stb[STB_INIT];
  assign bus.idle          = stb[STB_IDLE];
  assign bus.gen_move      = stb[STB_GEN];
  assign bus.apply_move    = stb[STB_APPLY];
  assign bus.draw          = stb[STB_DRAW];
  assign bus.draw_req      = (state == ST_REQ) || (state == ST_DRAW);
  assign bus.frame_overrun = overrun_q;
  assign bus.draw_timeout  = timeout_q;
  assign bus.move_phase    = phase;

endmodule

// File: doc/enemy_control.md
# enemy_control

Sequencing controller for the enemy datapath. It drives the one-hot phase strobes `init`, `idle`, `gen_move`, `apply_move` and `draw` into the enemy block. It paces enemy movement from the frame tick and requests the shared VGA write port from the screen arbiter before each enemy redraw. It sits between the top-level game FSM/frame counter and the enemy block, and it supervises the draw phase with a timeout.

## Interface
Parameters:
- `MOVE_DIV`, 4: frame ticks per enemy move; other ticks trigger redraw only. Legal range 1–255.
- `INIT_CYCLES`, 2: cycles `init` is held after reset. Legal range 1–15.
- `DRAW_TIMEOUT`, 4096: maximum cycles in DRAW before abort. Legal range 2–65535.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high; all state returns to INIT on the next edge.
- `enable` in 1: game running; when low, new frame ticks are ignored.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `draw_grant` in 1: VGA arbiter grant; held while `draw_req` stays high.
- `draw_done` in 1: enemy block finished its sprite writes.
- `init`, `idle`, `gen_move`, `apply_move`, `draw` out 1 each: one-hot phase strobes to the enemy block.
- `draw_req` out 1: request for the VGA write port.
- `frame_overrun` out 1: sticky; a tick arrived while not in IDLE.
- `draw_timeout` out 1: sticky; DRAW was aborted.
- `move_phase` out 8: current divider count, for debug.

## Operation
- States: INIT, IDLE, GEN, APPLY, REQ, DRAW. Encoding is binary internally; all strobes are Moore-decoded from state.
- INIT: `init`=1. Stay INIT_CYCLES cycles, then go to IDLE.
- IDLE: `idle`=1. On `frame_tick` with `enable`=1:
  - If `move_phase`==MOVE_DIV-1: go to GEN and set `move_phase` to 0.
  - Otherwise: go to REQ and increment `move_phase`.
  - Ticks with `enable`=0 are discarded; `move_phase` holds.
- GEN: `gen_move`=1 for exactly 1 cycle, then APPLY.
- APPLY: `apply_move`=1 for exactly 1 cycle, then REQ.
- REQ: `draw_req`=1. Wait for `draw_grant`, then go to DRAW.
- DRAW: `draw`=1 and `draw_req`=1. On `draw_done`, go to IDLE and drop `draw_req` on that same transition.
  - A timeout counter starts at 0 on entry. If it reaches DRAW_TIMEOUT-1 without `draw_done`, go to IDLE and set `draw_timeout`.
- `draw_done` outside DRAW is ignored.
- `frame_tick` in any state other than IDLE (including INIT) sets `frame_overrun` and is dropped; it is not queued.
- `enable` falling mid-sequence does not abort; the sequence completes to IDLE.
- Sticky flags clear only on reset.
- Reset values: `init`=1, all other outputs 0, `move_phase`=0, counters 0.

## Timing
- Frame tick in IDLE at cycle t:
  - Move frame: `gen_move` at t+1, `apply_move` at t+2, `draw_req` at t+3.
  - Non-move frame: `draw_req` at t+1.
- Grant sampled high at cycle g: `draw` is asserted at g+1.
- `draw_done` sampled high at cycle d: `idle`=1 and `draw_req`=0 at d+1.
- Grant and done are never combinationally forwarded; minimum REQ→IDLE latency is 2 cycles.
- The timeout counter is 16 bits and saturates; it is compared against DRAW_TIMEOUT-1.
- The divider is 8 bits; MOVE_DIV=1 makes every frame a move frame.
- Reset asserted mid-DRAW: `draw` and `draw_req` fall and `init` rises on the next edge. No grant release handshake is issued; the arbiter must also be reset.

## Structure
- Shared package `zelda_pkg` holds:
  - the state localparams,
  - the phase-strobe bit order {init, idle, gen_move, apply_move, draw},
  - the default MOVE_DIV and DRAW_TIMEOUT.
- Sub-module `move_rate_divider`: 8-bit modulo-MOVE_DIV tick counter with `advance` input, `wrap` output and `count` output; reused by the link/projectile pacing.
- The timeout counter and INIT counter stay inline.

## Test plan
- Reset 3 cycles, release → `init` high exactly 2 cycles, then `idle`=1; all other outputs 0 throughout.
- MOVE_DIV=4, 8 ticks spaced 200 cycles, grant immediate, `draw_done` 10 cycles after `draw` → `gen_move` pulses on ticks 4 and 8 only; 8 `draw` phases; `move_phase` sequence 1,2,3,0,1,2,3,0.
- Tick at t, grant withheld 50 cycles → `draw_req` high from t+1 through grant and DRAW; `draw` rises 1 cycle after grant.
- Tick during DRAW → `frame_overrun`=1, no extra sequence, `move_phase` unchanged.
- DRAW_TIMEOUT=16, `draw_done` never asserted → IDLE after 16 DRAW cycles, `draw_timeout`=1, `draw_req`=0.
- Reset asserted in APPLY → next cycle `init`=1, `apply_move`=0, `move_phase`=0, sticky flags cleared.
